// File: rtl/multdiv.sv
// multdiv: 32-bit signed iterative multiplier (radix-4 Booth, 16 steps) and divider (non-restoring, 32 steps).
// Optional macro MULTDIV_EARLY_DIV0_EN: divide-by-zero completes one cycle after start without going busy.
module multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic               r_is_mult;
    logic               r_div0;
    logic               r_ovf;
    logic               r_neg;
    logic signed [64:0] r_prod;
    logic signed [31:0] r_mcand;
    logic signed [33:0] r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_dvs;

    logic               w_start;
    logic               w_early_div0;
    logic signed [33:0] w_mc34;
    logic signed [33:0] w_pp;
    logic signed [33:0] w_sum;
    logic signed [64:0] w_prod_next;
    logic signed [33:0] w_shift;
    logic signed [33:0] w_rem_next;
    logic [31:0]        w_final;
    logic               w_exc;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign w_start = ctrl_MULT | ctrl_DIV;

`ifdef MULTDIV_EARLY_DIV0_EN
    assign w_early_div0 = ctrl_DIV & ~ctrl_MULT & (data_operandB == 32'd0);
`else
    assign w_early_div0 = 1'b0;
`endif

    // Booth step: sign-extended partial product added to a 34-bit accumulator, then shift right by 2
    assign w_mc34 = {{2{r_mcand[31]}}, r_mcand};

    always_comb begin
        w_pp = '0;
        case (r_prod[2:0])
            3'b001, 3'b010: w_pp = w_mc34;
            3'b011:         w_pp = w_mc34 <<< 1;
            3'b100:         w_pp = -(w_mc34 <<< 1);
            3'b101, 3'b110: w_pp = -w_mc34;
            default:        w_pp = '0;
        endcase
    end

    assign w_sum       = {{2{r_prod[64]}}, r_prod[64:33]} + w_pp;
    assign w_prod_next = {w_sum, r_prod[32:2]};

    // Non-restoring step: subtract while the partial remainder is non-negative, add otherwise
    assign w_shift    = {r_rem[32:0], r_quo[31]};
    assign w_rem_next = r_rem[33] ? (w_shift + {2'b00, r_dvs}) : (w_shift - {2'b00, r_dvs});

    always_comb begin
        w_final = '0;
        w_exc   = 1'b0;
        if (r_is_mult) begin
            w_final = r_prod[32:1];
            w_exc   = (r_prod[64:33] != {32{r_prod[32]}});
        end else if (r_div0) begin
            w_final = '0;
            w_exc   = 1'b1;
        end else begin
            w_final = r_neg ? (~r_quo + 32'd1) : r_quo;
            w_exc   = r_ovf;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (w_start) begin
                r_cnt <= '0;
                if (ctrl_MULT)
                    r_state <= S_MULT;
                else if (w_early_div0)
                    r_state <= S_DONE;
                else
                    r_state <= S_DIV;
            end else begin
                case (r_state)
                    S_MULT: begin
                        busy <= 1'b1;
                        if (r_cnt == 6'd15)
                            r_state <= S_DONE;
                        else
                            r_cnt <= r_cnt + 6'd1;
                    end
                    S_DIV: begin
                        busy <= 1'b1;
                        if (r_cnt == 6'd31)
                            r_state <= S_DONE;
                        else
                            r_cnt <= r_cnt + 6'd1;
                    end
                    S_DONE: begin
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= w_final;
                        data_exception <= w_exc;
                        r_state        <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers carry no reset; a start always reloads them before use
    always_ff @(posedge clock) begin
        if (w_start) begin
            r_is_mult <= ctrl_MULT;
            r_mcand   <= data_operandA;
            r_prod    <= {32'd0, data_operandB, 1'b0};
            r_div0    <= (data_operandB == 32'd0);
            r_ovf     <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            r_neg     <= data_operandA[31] ^ data_operandB[31];
            r_rem     <= '0;
            r_quo     <= mag32(data_operandA);
            r_dvs     <= mag32(data_operandB);
        end else if (r_state == S_MULT) begin
            r_prod <= w_prod_next;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[30:0], ~w_rem_next[33]};
        end
    end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: expected result/cycle pushed at start, popped on data_resultRDY.
module tb_multdiv;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

`ifdef MULTDIV_EARLY_DIV0_EN
    localparam int DIV0_LAT = 1;
    localparam bit EARLY = 1'b1;
`else
    localparam int DIV0_LAT = 33;
    localparam bit EARLY = 1'b0;
`endif

    multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (q.size() == 0) begin
                chk("spurious_rdy", {63'd0, data_resultRDY}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdy_cycle", cyc, e.cyc);
                chk("result", data_result, e.res);
                chk("exception", data_exception, e.exc);
            end
        end
    end

    // Independent reference: 64-bit product, SV truncating division, plus the two special cases
    task automatic model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc, output int lat);
        longint sa, sb, p;
        int     qq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mult) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p[63:32] != {32{p[31]}});
            lat = 17;
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
            lat = DIV0_LAT;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
            lat = 33;
        end else begin
            qq  = $signed(a) / $signed(b);
            res = qq;
            exc = 1'b0;
            lat = 33;
        end
    endtask

    // Called on a negedge; edge k is the next posedge. Returns on the negedge after edge k.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee, input int lat, input bit push);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (push) begin
            e.cyc = cyc + 1 + lat;
            e.res = er;
            e.exc = ee;
            q.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic        ee;
        int          lat;
        exp_t        e;

        repeat (3) @(negedge clock);
        chk("rst_result", data_result, 0);
        chk("rst_exc", data_exception, 0);
        chk("rst_rdy", data_resultRDY, 0);
        chk("rst_busy", busy, 0);

        // Start on the very first edge after reset deassertion: 7 * -6
        reset = 1'b0;
        start_op(1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 17, 1);
        chk("busy_k", busy, 0);
        @(negedge clock);
        chk("busy_k1", busy, 1);
        repeat (15) @(negedge clock);
        chk("busy_k16", busy, 1);
        @(negedge clock);
        chk("busy_k17", busy, 0);
        wait_done(40);
        repeat (3) @(negedge clock);
        chk("hold_result", data_result, 32'hFFFF_FFD6);
        chk("hold_rdy_low", data_resultRDY, 0);

        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 17, 1);
        wait_done(40);
        start_op(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33, 1);
        wait_done(60);

        // Divide by zero: latency depends on the early-completion option
        start_op(0, 1, 32'd5, 32'd0, 32'd0, 1'b1, DIV0_LAT, 1);
        chk("div0_busy_k", busy, 0);
        @(negedge clock);
        chk("div0_busy_k1", busy, EARLY ? 1'b0 : 1'b1);
        wait_done(60);

        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33, 1);
        wait_done(60);

        // Abort: MULT at k, DIV 20/3 at k+5 -> single pulse at k+38
        start_op(1, 0, 32'd11, 32'd13, 32'd0, 1'b0, 17, 0);
        repeat (4) @(negedge clock);
        start_op(0, 1, 32'd20, 32'd3, 32'd6, 1'b0, 33, 1);
        wait_done(60);

        // Both starts together: multiply wins
        start_op(1, 1, 32'd3, 32'd4, 32'd12, 1'b0, 17, 1);
        wait_done(40);

        // Three-cycle-wide start pulse restarts on each sampled edge
        data_operandA = 32'hFFFF_FFFB;
        data_operandB = 32'hFFFF_FFF7;
        ctrl_MULT     = 1'b1;
        e.cyc = cyc + 3 + 17;
        e.res = 32'd45;
        e.exc = 1'b0;
        q.push_back(e);
        repeat (3) @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_done(40);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : ((i % 3 == 1) ? {{16{ra[31]}}, 16'($urandom)} : 32'($urandom));
            model(i[0], ra, rb, er, ee, lat);
            start_op(i[0], ~i[0], ra, rb, er, ee, lat, 1);
            wait_done(60);
        end

        // Reset mid-divide: outputs clear at once and no completion follows
        start_op(0, 1, 32'd1000, 32'd3, 32'd0, 1'b0, 33, 0);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("midrst_result", data_result, 0);
        chk("midrst_exc", data_exception, 0);
        chk("midrst_rdy", data_resultRDY, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("midrst_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clock  input  1  master clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 data_operandA  input  32  operand A: multiplicand or dividend, two's complement.
REQ-005 data_operandB  input  32  operand B: multiplier or divisor, two's complement.
REQ-006 ctrl_MULT  input  1  one-cycle start pulse for a signed multiply.
REQ-007 ctrl_DIV  input  1  one-cycle start pulse for a signed divide.
REQ-008 data_result  output  32  low 32 bits of the product, or the quotient.
REQ-009 data_exception  output  1  overflow or divide-by-zero flag; valid while data_resultRDY is high.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while an operation is in flight; the execute stage stalls on it.

Function
REQ-012 The block SHALL implement FSM states IDLE, MULT, DIV and DONE, with a 6-bit iteration counter.
REQ-013 Operands SHALL be latched on the rising edge (edge k) that samples ctrl_MULT or ctrl_DIV high; operand inputs are don't-care after edge k.
REQ-014 If ctrl_MULT and ctrl_DIV are sampled high on the same edge, the block SHALL perform MULT and ignore DIV.
REQ-015 MULT SHALL use radix-4 modified Booth: 16 iterations, a 65-bit product register and sign-extended partial products.
REQ-016 MULT: data_resultRDY SHALL be high exactly between edges k+17 and k+18.
REQ-017 MULT: data_exception SHALL be 1 if and only if product[63:32] is not the sign extension of product[31].
REQ-018 DIV SHALL use non-restoring division on operand magnitudes: 32 iterations, then one sign-fix cycle; the quotient truncates toward zero and the remainder is discarded.
REQ-019 DIV: data_resultRDY SHALL be high exactly between edges k+33 and k+34.
REQ-020 DIV with divisor 0 SHALL give data_result = 0 and data_exception = 1.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give data_result = 0x80000000 and data_exception = 1.
REQ-022 busy SHALL be high from edge k+1 until the edge on which data_resultRDY rises, then low.
REQ-023 data_result and data_exception SHALL hold their final values after data_resultRDY falls, until the next start is sampled.
REQ-024 A start sampled while busy SHALL abort the current operation with no data_resultRDY pulse, and SHALL restart timing from the new edge k.
REQ-025 Counter wrap SHALL NOT occur: the counter saturates at its terminal count and the FSM moves to DONE, then to IDLE one cycle later.
REQ-026 Start pulses wider than one cycle SHALL restart the operation on every sampled-high edge.

Reset
REQ-027 Reset high SHALL asynchronously force: FSM = IDLE, counter = 0, data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
REQ-028 Reset mid-operation SHALL discard the operation with no data_resultRDY pulse.
REQ-029 A start pulse on the first edge after reset deasserts SHALL be accepted.

Configuration
REQ-030 With macro MULTDIV_EARLY_DIV0_EN defined, DIV with divisor 0 SHALL complete at edge k+1: data_resultRDY is high between edges k+1 and k+2, result = 0, exception = 1, and busy stays low.
REQ-031 Without MULTDIV_EARLY_DIV0_EN, DIV with divisor 0 SHALL take the full 33-cycle latency of REQ-019, with the results of REQ-020.

Verification
REQ-032 Bench: ctrl_MULT, A = 7, B = -6 -> data_resultRDY at k+17, data_result = 0xFFFFFFD6, data_exception = 0.
REQ-033 Bench: ctrl_MULT, A = 0x00010000, B = 0x00010000 -> data_resultRDY at k+17, data_result = 0x00000000, data_exception = 1.
REQ-034 Bench: ctrl_DIV, A = -100, B = 7 -> data_resultRDY at k+33, data_result = 0xFFFFFFF2, data_exception = 0.
REQ-035 Bench: ctrl_DIV, A = 5, B = 0 -> result 0 and exception 1, with data_resultRDY at k+33 without the macro and at k+1 with MULTDIV_EARLY_DIV0_EN.
REQ-036 Bench: ctrl_MULT at edge k, then ctrl_DIV (20 / 3) at k+5 -> a single data_resultRDY at k+38 with data_result = 6, and no pulse at k+17.
REQ-037 Bench: ctrl_DIV, then reset asserted at k+10 -> all outputs 0 immediately, and data_resultRDY never rises.
